// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg - shared defaults and address-legality helper for the register bank
// Revision: 1.0
`default_nettype none

package reg_bank_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;

  // An address is usable when it maps to a real register that is not the hardwired zero.
  function automatic bit addr_legal(input int addr, input int depth, input bit zero_reg0);
    return (addr < depth) && !(zero_reg0 && (addr == 0));
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bank_2r1w_if.sv
// reg_bank_2r1w_if - write/read bus of the register bank
// Revision: 1.0
`default_nettype none

interface reg_bank_2r1w_if
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic              EN;
  logic [ADDR_W-1:0] W_Addr;
  logic [WIDTH-1:0]  Reg_In;
  logic [ADDR_W-1:0] R1_Addr;
  logic [ADDR_W-1:0] R2_Addr;
  logic [WIDTH-1:0]  Reg1_Out;
  logic [WIDTH-1:0]  Reg2_Out;

  modport master (
    output EN, W_Addr, Reg_In, R1_Addr, R2_Addr,
    input  Reg1_Out, Reg2_Out
  );

  modport slave (
    input  EN, W_Addr, Reg_In, R1_Addr, R2_Addr,
    output Reg1_Out, Reg2_Out
  );

endinterface

`default_nettype wire

// File: rtl/reg_bank_rport.sv
// reg_bank_rport - one read port: decode, masking and optional output register with write bypass
// Revision: 1.0
`default_nettype none

module reg_bank_rport
  import reg_bank_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ZERO_REG0 = 0,
  parameter int READ_REG  = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DEPTH*WIDTH-1:0] mem_flat,
  input  logic                   wr_legal,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data
);

  logic             w_rd_legal;
  logic [WIDTH-1:0] w_rd_raw;

  assign w_rd_legal = addr_legal(int'(addr), DEPTH, ZERO_REG0 != 0);

  always_comb begin
    w_rd_raw = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        w_rd_raw = mem_flat[i*WIDTH +: WIDTH];
      end
    end
    if (!w_rd_legal) begin
      w_rd_raw = '0;
    end
  end

  generate
    if (READ_REG != 0) begin : g_reg
      logic [WIDTH-1:0] r_data;
      logic             w_hit;

      // wr_legal already excludes discarded writes, so a hit implies a legal read address.
      assign w_hit = wr_legal && (wr_addr == addr);

      always_ff @(posedge clk) begin
        if (res) begin
          r_data <= '0;
        end else begin
          r_data <= w_hit ? wr_data : w_rd_raw;
        end
      end

      assign rd_data = r_data;
    end else begin : g_comb
      logic w_unused;
      assign w_unused = ^{clk, res, wr_legal, wr_addr, wr_data};
      assign rd_data  = w_rd_raw;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/reg_bank_2r1w.sv
// reg_bank_2r1w - DEPTH x WIDTH register bank with one write port and two read ports
// Revision: 1.0
`default_nettype none

module reg_bank_2r1w
  import reg_bank_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ZERO_REG0 = 0,
  parameter int READ_REG  = 0
) (
  input logic            clk,
  input logic            res,
  reg_bank_2r1w_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] w_mem_flat;
  logic                   w_wr_legal;

  assign w_wr_legal = bus.EN && addr_legal(int'(bus.W_Addr), DEPTH, ZERO_REG0 != 0);

  // Reset outranks the write enable, so a write in a reset cycle is lost.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_legal) begin
      r_mem[bus.W_Addr] <= bus.Reg_In;
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign w_mem_flat[g*WIDTH +: WIDTH] = r_mem[g];
    end
  endgenerate

  reg_bank_rport #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ZERO_REG0 (ZERO_REG0),
    .READ_REG  (READ_REG)
  ) u_rport1 (
    .clk      (clk),
    .res      (res),
    .addr     (bus.R1_Addr),
    .mem_flat (w_mem_flat),
    .wr_legal (w_wr_legal),
    .wr_addr  (bus.W_Addr),
    .wr_data  (bus.Reg_In),
    .rd_data  (bus.Reg1_Out)
  );

  reg_bank_rport #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ZERO_REG0 (ZERO_REG0),
    .READ_REG  (READ_REG)
  ) u_rport2 (
    .clk      (clk),
    .res      (res),
    .addr     (bus.R2_Addr),
    .mem_flat (w_mem_flat),
    .wr_legal (w_wr_legal),
    .wr_addr  (bus.W_Addr),
    .wr_data  (bus.Reg_In),
    .rd_data  (bus.Reg2_Out)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_2r1w.sv
// tb_reg_bank_2r1w - directed checks over four configurations of the register bank
// Revision: 1.0
`default_nettype none

module tb_reg_bank_2r1w;

  logic clk;
  logic res;

  // Shared stimulus for the three 8x8 instances.
  logic       en;
  logic [2:0] wa;
  logic [7:0] wd;
  logic [2:0] ra1;
  logic [2:0] ra2;

  // Stimulus for the 16-bit, 5-deep instance.
  logic        en3;
  logic [2:0]  wa3;
  logic [15:0] wd3;
  logic [2:0]  ra13;
  logic [2:0]  ra23;

  int n_checks;
  int n_fail;

  reg_bank_2r1w_if #(.WIDTH(8),  .DEPTH(8)) b0 ();
  reg_bank_2r1w_if #(.WIDTH(8),  .DEPTH(8)) b1 ();
  reg_bank_2r1w_if #(.WIDTH(8),  .DEPTH(8)) b2 ();
  reg_bank_2r1w_if #(.WIDTH(16), .DEPTH(5)) b3 ();

  assign b0.EN = en;  assign b0.W_Addr = wa;  assign b0.Reg_In = wd;  assign b0.R1_Addr = ra1;  assign b0.R2_Addr = ra2;
  assign b1.EN = en;  assign b1.W_Addr = wa;  assign b1.Reg_In = wd;  assign b1.R1_Addr = ra1;  assign b1.R2_Addr = ra2;
  assign b2.EN = en;  assign b2.W_Addr = wa;  assign b2.Reg_In = wd;  assign b2.R1_Addr = ra1;  assign b2.R2_Addr = ra2;
  assign b3.EN = en3; assign b3.W_Addr = wa3; assign b3.Reg_In = wd3; assign b3.R1_Addr = ra13; assign b3.R2_Addr = ra23;

  reg_bank_2r1w #(.WIDTH(8),  .DEPTH(8), .ZERO_REG0(0), .READ_REG(0)) u_comb  (.clk(clk), .res(res), .bus(b0));
  reg_bank_2r1w #(.WIDTH(8),  .DEPTH(8), .ZERO_REG0(0), .READ_REG(1)) u_reg   (.clk(clk), .res(res), .bus(b1));
  reg_bank_2r1w #(.WIDTH(8),  .DEPTH(8), .ZERO_REG0(1), .READ_REG(1)) u_zero  (.clk(clk), .res(res), .bus(b2));
  reg_bank_2r1w #(.WIDTH(16), .DEPTH(5), .ZERO_REG0(0), .READ_REG(0)) u_wide  (.clk(clk), .res(res), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    res = 1'b1; en = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    en3 = 1'b0; wa3 = '0; wd3 = '0; ra13 = '0; ra23 = '0;
    tick();
    res = 1'b0;

    // Reset clear
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; wa = 3'(i); wd = 8'hAA;
      tick();
    end
    en = 1'b0;
    ra1 = 3'd5;
    #1;
    check("fill_comb_r5", 32'(b0.Reg1_Out), 32'h00AA);
    res = 1'b1;
    tick();
    res = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(i);
      tick();
      check($sformatf("rst_comb_p1_a%0d", i), 32'(b0.Reg1_Out), 32'h0);
      check($sformatf("rst_comb_p2_a%0d", i), 32'(b0.Reg2_Out), 32'h0);
      check($sformatf("rst_reg_p1_a%0d", i),  32'(b1.Reg1_Out), 32'h0);
      check($sformatf("rst_reg_p2_a%0d", i),  32'(b1.Reg2_Out), 32'h0);
    end

    // Reset beats a simultaneous write
    en = 1'b1; wa = 3'd3; wd = 8'hAA;
    tick();
    res = 1'b1; wd = 8'h55;
    tick();
    res = 1'b0; en = 1'b0; ra1 = 3'd3;
    tick();
    check("rst_prio_comb", 32'(b0.Reg1_Out), 32'h0);
    check("rst_prio_reg",  32'(b1.Reg1_Out), 32'h0);

    // Write then hold; read-during-write shows old data on the combinational bank
    ra1 = 3'd2; en = 1'b1; wa = 3'd2; wd = 8'h77;
    #1;
    check("rdw_old_comb", 32'(b0.Reg1_Out), 32'h0);
    tick();
    en = 1'b0; wd = 8'h00;
    check("wr_comb", 32'(b0.Reg1_Out), 32'h77);
    check("wr_reg",  32'(b1.Reg1_Out), 32'h77);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_comb_%0d", k), 32'(b0.Reg1_Out), 32'h77);
      check($sformatf("hold_reg_%0d", k),  32'(b1.Reg1_Out), 32'h77);
    end

    // Dual read and address swap latency
    en = 1'b1; wa = 3'd1; wd = 8'h11;
    tick();
    wa = 3'd6; wd = 8'h66;
    tick();
    en = 1'b0; ra1 = 3'd1; ra2 = 3'd6;
    tick();
    check("dual_comb_p1", 32'(b0.Reg1_Out), 32'h11);
    check("dual_comb_p2", 32'(b0.Reg2_Out), 32'h66);
    check("dual_reg_p1",  32'(b1.Reg1_Out), 32'h11);
    check("dual_reg_p2",  32'(b1.Reg2_Out), 32'h66);
    ra1 = 3'd6; ra2 = 3'd1;
    #1;
    check("swap_comb_p1", 32'(b0.Reg1_Out), 32'h66);
    check("swap_comb_p2", 32'(b0.Reg2_Out), 32'h11);
    check("swap_reg_pre_p1", 32'(b1.Reg1_Out), 32'h11);
    check("swap_reg_pre_p2", 32'(b1.Reg2_Out), 32'h66);
    tick();
    check("swap_reg_p1", 32'(b1.Reg1_Out), 32'h66);
    check("swap_reg_p2", 32'(b1.Reg2_Out), 32'h11);

    // Write-first bypass on the registered bank
    en = 1'b1; wa = 3'd4; wd = 8'h10; ra1 = 3'd4; ra2 = 3'd4;
    tick();
    check("byp_first", 32'(b1.Reg1_Out), 32'h10);
    wd = 8'h3C;
    tick();
    en = 1'b0;
    check("byp_reg_p1",  32'(b1.Reg1_Out), 32'h3C);
    check("byp_reg_p2",  32'(b1.Reg2_Out), 32'h3C);
    check("byp_comb_p1", 32'(b0.Reg1_Out), 32'h3C);

    // Hardwired register 0, including suppressed bypass
    en = 1'b1; wa = 3'd0; wd = 8'hFF; ra1 = 3'd0; ra2 = 3'd0;
    tick();
    en = 1'b0;
    check("z0_byp_p1", 32'(b2.Reg1_Out), 32'h0);
    check("z0_byp_p2", 32'(b2.Reg2_Out), 32'h0);
    check("nz0_byp",   32'(b1.Reg1_Out), 32'h00FF);
    tick();
    check("z0_after",  32'(b2.Reg1_Out), 32'h0);
    check("nz0_after", 32'(b0.Reg1_Out), 32'h00FF);
    ra1 = 3'd4;
    tick();
    check("z0_r4", 32'(b2.Reg1_Out), 32'h3C);

    // 16-bit, 5-deep: legal top address and out-of-range handling
    en3 = 1'b1; wa3 = 3'd4; wd3 = 16'hBEEF;
    tick();
    en3 = 1'b0; ra13 = 3'd4;
    #1;
    check("wide_a4", 32'(b3.Reg1_Out), 32'hBEEF);
    en3 = 1'b1; wa3 = 3'd6; wd3 = 16'h1234;
    tick();
    en3 = 1'b0; ra23 = 3'd6;
    #1;
    check("wide_a6_rd", 32'(b3.Reg2_Out), 32'h0);
    check("wide_a4_keep", 32'(b3.Reg1_Out), 32'hBEEF);
    ra13 = 3'd2;
    #1;
    check("wide_a2_noalias", 32'(b3.Reg1_Out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
